// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier (and, later, the
// restoring divider that pairs with it).
package mult_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // True when a double-width result does not fit in the lower half.
  function automatic logic upper_nonzero(input logic [2*WIDTH-1:0] value);
    return (value[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/multiplication.sv
// Iterative unsigned multiply-accumulate: P = A*B + C, one multiplier bit per
// clock, with a start/busy/done handshake.
module multiplication
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     C,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P,
  output logic                 ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  p_q, p_d;
  logic                ovf_q, ovf_d;
  logic [2*WIDTH-1:0]  partial_s;

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      cnt_q    <= {CW{1'b0}};
      p_q      <= {(2*WIDTH){1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state, add/shift and result-capture logic.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    ovf_d     = ovf_q;
    partial_s = {{WIDTH{1'b0}}, mcand_q} << cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = A;
          mplier_d = B;
          acc_d    = {{WIDTH{1'b0}}, C};
          cnt_d    = {CW{1'b0}};
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + partial_s;
        end else begin
          acc_d = acc_q;
        end
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // The final partial product goes straight into P so it is valid with done.
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          p_d     = acc_d;
          ovf_d   = upper_nonzero(acc_d);
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign P    = p_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_multiplication.sv
// Self-checking bench for the iterative multiplier: directed cases plus
// random operands against a plain-arithmetic reference.
module tb_multiplication;

  localparam int W = 16;

  logic            clk;
  logic            rst;
  logic            start;
  logic [W-1:0]    A, B, C;
  logic            busy, done, ovf;
  logic [2*W-1:0]  P;

  int n_checks;
  int n_fail;
  logic [2*W-1:0] prev_p;

  multiplication #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .C     (C),
    .busy  (busy),
    .done  (done),
    .P     (P),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_p(input logic [W-1:0] a, b, c);
    return 64'(a) * 64'(b) + 64'(c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: perturb_at >= 0 pulses start and scrambles operands at
  // that RUN cycle; start_in_done pulses start during the DONE cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, b, c,
                        input int perturb_at, input bit start_in_done);
    logic [63:0] exp;
    int edges;
    int busy_cycles;
    bit seen;
    exp = ref_p(a, b, c);
    @(negedge clk);
    A = a; B = b; C = c; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      if (P !== prev_p) check_eq({tag, "_p_hold_run"}, 64'(P), 64'(prev_p));
      if (busy_cycles == perturb_at) begin
        A = {W{1'b1}}; B = {W{1'b1}}; C = {W{1'b1}}; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      edges++;
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
    check_eq({tag, "_latency"}, 64'(edges + 1), 64'(W + 1));
    check_eq({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(W));
    check_eq({tag, "_P"}, 64'(P), exp);
    check_eq({tag, "_ovf"}, 64'(ovf), 64'(exp[63:W] != 0));
    if (start_in_done) start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, "_done_drop"}, 64'(done), 64'd0);
    check_eq({tag, "_idle_after"}, 64'(busy), 64'd0);
    check_eq({tag, "_P_held"}, 64'(P), exp);
    tick();
    check_eq({tag, "_no_restart"}, 64'({busy, done}), 64'd0);
    prev_p = exp[2*W-1:0];
  endtask

  initial begin
    int last_done;
    int pulses;
    int cyc;
    logic [W-1:0] ra, rb, rc;
    n_checks = 0;
    n_fail   = 0;
    prev_p   = '0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; C = '0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    check_eq("reset_P", 64'(P), 64'd0);
    check_eq("reset_ovf", 64'(ovf), 64'd0);

    run_op("basic", 16'd3, 16'd5, 16'd0, -1, 1'b0);
    run_op("rt1", 16'h0007, 16'h0009, 16'h0004, -1, 1'b0);
    check_eq("rt1_value", 64'(P), 64'h43);
    run_op("rt2", 16'h0ABC, 16'h0003, 16'h0001, -1, 1'b0);
    check_eq("rt2_value", 64'(P), 64'h2035);
    run_op("max", 16'hFFFF, 16'hFFFF, 16'hFFFF, -1, 1'b0);
    check_eq("max_value", 64'(P), 64'hFFFF0000);
    run_op("zeroA", 16'h0000, 16'h1234, 16'hABCD, -1, 1'b0);
    run_op("isolate", 16'd2, 16'd3, 16'd1, 5, 1'b1);
    check_eq("isolate_value", 64'(P), 64'd7);
    run_op("pre_rst", 16'd3, 16'd5, 16'd0, -1, 1'b0);

    // Reset in the middle of an operation.
    @(negedge clk);
    A = 16'h0100; B = 16'h0100; C = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_eq("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_mid_busy", 64'(busy), 64'd0);
    check_eq("rst_mid_done", 64'(done), 64'd0);
    check_eq("rst_mid_P", 64'(P), 64'd0);
    check_eq("rst_mid_ovf", 64'(ovf), 64'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    check_eq("rst_mid_quiet", 64'(pulses), 64'd0);
    prev_p = '0;
    run_op("post_rst", 16'h0100, 16'h0100, 16'h0000, -1, 1'b0);

    // Random operands against the arithmetic reference.
    for (int k = 0; k < 12; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = W'($urandom);
      if (k == 3) rb = '0;
      if (k == 7) ra = {W{1'b1}};
      run_op("rand", ra, rb, rc, -1, 1'b0);
    end

    // Start held high: done every 18 cycles.
    @(negedge clk);
    A = 16'd1; B = 16'd1; C = 16'd0; start = 1'b1;
    last_done = -1;
    pulses = 0;
    cyc = 0;
    while (pulses < 4 && cyc < 200) begin
      tick();
      cyc++;
      if (done) begin
        check_eq("b2b_P", 64'(P), 64'd1);
        if (last_done >= 0) check_eq("b2b_period", 64'(cyc - last_done), 64'd18);
        last_done = cyc;
        pulses++;
      end
    end
    start = 1'b0;
    check_eq("b2b_pulses", 64'(pulses), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplication.md
Name: multiplication

Overview:
- Sequential shift-and-add unsigned multiplier with an accumulate input. Computes P = A*B + C.
- Inverse of the team's combinational restoring divider: feeding it (Q, D, R) rebuilds N = Q*D + R. Used to rescale temperature readings and to self-check divider results.
- Iterative: one multiplier bit per clock, with a start/busy/done handshake, so it stays small enough for the sensor datapath.

Parameters:
- WIDTH, 16, operand width in bits. The product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  multiplicand (divider quotient in round-trip use)
- B  input  WIDTH  multiplier (divider divisor)
- C  input  WIDTH  addend (divider remainder)
- busy  output  1  high while iterating (RUN)
- done  output  1  one-cycle pulse; P/ovf valid from this cycle on
- P  output  2*WIDTH  result A*B + C, held until the next completion
- ovf  output  1  high when P[2*WIDTH-1:WIDTH] != 0 (result does not fit WIDTH bits)

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, busy=0, done=0, P=0, ovf=0, internal registers cleared.
  - Reset has priority over everything, including mid-RUN; the operation in progress is discarded.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 at edge E0 latches A, B and C into internal registers and sets acc = zero-extended C, cnt=0, state=RUN.
  - start=0: remain in IDLE.
- RUN (edges E1..E16 for WIDTH=16):
  - If mplier[0]=1, acc += mcand << cnt, computed in 2*WIDTH bits. Then mplier >>= 1 and cnt++.
  - After the WIDTH-th RUN edge, state=DONE and P/ovf are loaded from the final acc.
  - Equivalent right-shifting-accumulator implementations are allowed if cycle timing and results are identical.
- DONE: lasts exactly one cycle, then state=IDLE unconditionally.
- Outputs per state:
  - busy=1 exactly in RUN, i.e. WIDTH cycles.
  - done=1 exactly in DONE.
  - done is visible in the cycle after edge E(WIDTH). Start-to-done latency is WIDTH+1 edges (17 for the default).
- start in RUN or DONE is ignored; there is no queuing. The earliest back-to-back start is sampled in the first IDLE cycle after DONE.
- Latched operands are isolated: changes to A, B or C during RUN or DONE do not affect the result.
- P and ovf change only on entry to DONE (or on reset). During a following RUN they keep the previous result.
- Width rule: the maximum result is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, so the 2*WIDTH-bit P never wraps. There is no carry-out port.
- A=0 or B=0: still takes the full WIDTH cycles (no early termination); P = C.
- ovf is registered with P. It is combinationally equivalent to the upper half of P being non-zero.

Decomposition:
- Shared package (mult_pkg):
  - state enum {IDLE, RUN, DONE}
  - default WIDTH=16
  - counter width constant CNT_W = $clog2(WIDTH)
- The divider can later import WIDTH from the same package.
- No sub-module. The adder, shifter and counter live in one process with a separate state register.

Test Plan:
- Basic: A=3, B=5, C=0, start at E0 -> busy=1 for 16 cycles, done pulse after E16, P=0x0000000F, ovf=0. P stays 15 after done drops.
- Divider round trip: A=0x0007, B=0x0009, C=0x0004 (from N=67/D=9) -> P=0x00000043, ovf=0. Also A=0x0ABC, B=0x0003, C=0x0001 -> P=0x00002035.
- Extreme: A=0xFFFF, B=0xFFFF, C=0xFFFF -> P=0xFFFF0000, ovf=1. Then A=0, B=0x1234, C=0xABCD -> P=0x0000ABCD, ovf=0, latency still 17 edges.
- Isolation and ignore:
  - Start A=2, B=3, C=1.
  - At RUN cycle 5, change A/B/C to 0xFFFF and pulse start.
  - Required: P=0x00000007, a single done pulse, no second operation.
  - Start asserted in the DONE cycle is also ignored.
- Reset mid-operation:
  - Start A=0x0100, B=0x0100, C=0 after a prior result of P=15.
  - Assert rst for one edge at RUN cycle 8 -> next cycle busy=0, done=0, P=0, ovf=0, state IDLE, no done pulse.
  - A fresh start with A=0x0100, B=0x0100 then gives P=0x00010000, ovf=1.
- Back-to-back: start held high continuously with A=1, B=1, C=0 -> done pulses exactly every 18 cycles (17 edges to done plus one IDLE cycle), each with P=1.
